// File: rtl/prog_counter_if.sv
// ---------------------------------------------------------------------------
// prog_counter_if
// Groups the control inputs and the count outputs of prog_counter into one
// bundle. Clock and asynchronous reset stay as plain ports on the module.
//
// Signals:
//   counter_RST_SYN  synchronous clear, active-low
//   counter_En       count enable; low clears count and prescaler
//   counter_Load     parallel load strobe
//   load_value       value to load; also captured as the wrap reload value
//   terminal_value   terminal count
//   dir_up           1 = increment, 0 = decrement
//   mode_wrap        1 = wrap at terminal, 0 = saturate at terminal
//   prescale         one step every prescale+1 enabled cycles
//   count            current count, registered
//   counter_finish   combinational: count == terminal_value
//   counter_tick     registered one-cycle pulse when a step lands on terminal
//
// Modports:
//   master  drives the controls and observes the count (e.g. a UART TX FSM)
//   slave   the counter itself
//
// This interface carries no valid/ready handshake. Every control is sampled
// on each rising clock edge, and the outputs are valid in every cycle.
// ---------------------------------------------------------------------------
interface prog_counter_if #(
  parameter int CNT_WIDTH   = 4,
  parameter int PRESC_WIDTH = 8
);
  logic                   counter_RST_SYN;
  logic                   counter_En;
  logic                   counter_Load;
  logic [CNT_WIDTH-1:0]   load_value;
  logic [CNT_WIDTH-1:0]   terminal_value;
  logic                   dir_up;
  logic                   mode_wrap;
  logic [PRESC_WIDTH-1:0] prescale;
  logic [CNT_WIDTH-1:0]   count;
  logic                   counter_finish;
  logic                   counter_tick;

  modport master (
    output counter_RST_SYN, counter_En, counter_Load, load_value,
           terminal_value, dir_up, mode_wrap, prescale,
    input  count, counter_finish, counter_tick
  );

  modport slave (
    input  counter_RST_SYN, counter_En, counter_Load, load_value,
           terminal_value, dir_up, mode_wrap, prescale,
    output count, counter_finish, counter_tick
  );
endinterface

// File: rtl/prog_counter.sv
// ---------------------------------------------------------------------------
// prog_counter
// A parametrised programmable counter for the UART TX datapath. It is used
// both as the bit-index counter and as the oversample/baud divider. It
// supports a programmable terminal value, an up or down direction, a wrap
// or saturate mode, a parallel load, and a clock prescaler.
//
// Ports:
//   counter_CLK       clock, rising edge
//   counter_RST_ASYN  asynchronous reset, active-low
//   bus               prog_counter_if.slave (controls in, count/finish/tick out)
//
// Synchronous priority on each edge is:
//   RST_SYN low > Load > En low > step > hold
//
// The CNT_WIDTH and PRESC_WIDTH parameters must match the parameters of the
// connected interface instance.
// ---------------------------------------------------------------------------
module prog_counter #(
  parameter int CNT_WIDTH   = 4,
  parameter int PRESC_WIDTH = 8
) (
  input  logic          counter_CLK,
  input  logic          counter_RST_ASYN,
  prog_counter_if.slave bus
);

  logic [CNT_WIDTH-1:0]   count_q,  count_d;
  logic [CNT_WIDTH-1:0]   reload_q, reload_d;
  logic [PRESC_WIDTH-1:0] presc_q,  presc_d;
  logic                   tick_q,   tick_d;

  logic                   finish;
  logic                   step_en;
  logic [CNT_WIDTH-1:0]   step_val;

  assign finish  = (count_q == bus.terminal_value);
  // The comparison uses >= rather than ==. If prescale is lowered below the
  // running prescaler value, the counter steps on the next cycle instead of
  // running all the way round the prescaler.
  assign step_en = (presc_q >= bus.prescale);
  // The step is taken modulo 2^CNT_WIDTH. Counting away from the terminal
  // therefore wraps through 0 or through all-ones.
  assign step_val = bus.dir_up ? (count_q + CNT_WIDTH'(1))
                               : (count_q - CNT_WIDTH'(1));

  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    presc_d  = presc_q;
    tick_d   = 1'b0;
    if (!bus.counter_RST_SYN) begin
      count_d  = '0;
      reload_d = '0;
      presc_d  = '0;
    end else if (bus.counter_Load) begin
      count_d  = bus.load_value;
      reload_d = bus.load_value;
      presc_d  = '0;
    end else if (!bus.counter_En) begin
      count_d = '0;
      presc_d = '0;
    end else if (finish && !bus.mode_wrap) begin
      // Saturated: the count holds and the prescaler stays parked at 0.
      presc_d = '0;
    end else if (step_en) begin
      presc_d = '0;
      if (finish) begin
        count_d = reload_q;
        tick_d  = (reload_q == bus.terminal_value);
      end else begin
        count_d = step_val;
        tick_d  = (step_val == bus.terminal_value);
      end
    end else begin
      presc_d = presc_q + PRESC_WIDTH'(1);
    end
  end

  always_ff @(posedge counter_CLK or negedge counter_RST_ASYN) begin
    if (!counter_RST_ASYN) begin
      count_q  <= '0;
      reload_q <= '0;
      presc_q  <= '0;
      tick_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      presc_q  <= presc_d;
      tick_q   <= tick_d;
    end
  end

  assign bus.count          = count_q;
  assign bus.counter_finish = finish;
  assign bus.counter_tick   = tick_q;

endmodule

// File: tb/tb_prog_counter.sv
// ---------------------------------------------------------------------------
// tb_prog_counter
// Drives a 4-bit and a 3-bit prog_counter from the same stimulus. The 3-bit
// instance receives the low bits of load_value and terminal_value. A
// behavioural model of both counters is checked against the outputs after
// every edge, and directed scenarios pin the model with literal expectations.
// ---------------------------------------------------------------------------
module tb_prog_counter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       rst_syn, en, load, dir, wrap;
  logic [3:0] lv, tv;
  logic [7:0] ps;

  prog_counter_if #(.CNT_WIDTH(4), .PRESC_WIDTH(8)) if4 ();
  prog_counter_if #(.CNT_WIDTH(3), .PRESC_WIDTH(8)) if3 ();

  assign if4.counter_RST_SYN = rst_syn;
  assign if4.counter_En      = en;
  assign if4.counter_Load    = load;
  assign if4.load_value      = lv;
  assign if4.terminal_value  = tv;
  assign if4.dir_up          = dir;
  assign if4.mode_wrap       = wrap;
  assign if4.prescale        = ps;

  assign if3.counter_RST_SYN = rst_syn;
  assign if3.counter_En      = en;
  assign if3.counter_Load    = load;
  assign if3.load_value      = lv[2:0];
  assign if3.terminal_value  = tv[2:0];
  assign if3.dir_up          = dir;
  assign if3.mode_wrap       = wrap;
  assign if3.prescale        = ps;

  prog_counter #(.CNT_WIDTH(4), .PRESC_WIDTH(8)) u_dut4 (
    .counter_CLK      (clk),
    .counter_RST_ASYN (rst_n),
    .bus              (if4)
  );

  prog_counter #(.CNT_WIDTH(3), .PRESC_WIDTH(8)) u_dut3 (
    .counter_CLK      (clk),
    .counter_RST_ASYN (rst_n),
    .bus              (if3)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // Index 0 is the 4-bit counter and index 1 is the 3-bit counter.
  int m_cnt[2];
  int m_rel[2];
  int m_presc[2];
  int m_tick[2];
  int msk[2] = '{15, 7};

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_rel[k] = 0; m_presc[k] = 0; m_tick[k] = 0;
    end
  endfunction

  function automatic void model_edge();
    for (int k = 0; k < 2; k++) begin
      int t;
      t = int'(tv) & msk[k];
      m_tick[k] = 0;
      if (!rst_syn) begin
        m_cnt[k] = 0; m_rel[k] = 0; m_presc[k] = 0;
      end else if (load) begin
        m_cnt[k] = int'(lv) & msk[k];
        m_rel[k] = m_cnt[k];
        m_presc[k] = 0;
      end else if (!en) begin
        m_cnt[k] = 0; m_presc[k] = 0;
      end else if (m_cnt[k] == t && !wrap) begin
        m_presc[k] = 0;
      end else if (m_presc[k] >= int'(ps)) begin
        m_presc[k] = 0;
        if (m_cnt[k] == t) m_cnt[k] = m_rel[k];
        else m_cnt[k] = (m_cnt[k] + (dir ? 1 : -1)) & msk[k];
        m_tick[k] = (m_cnt[k] == t) ? 1 : 0;
      end else begin
        m_presc[k] = m_presc[k] + 1;
      end
    end
  endfunction

  function automatic void compare_all();
    check("cnt4",  int'(if4.count),          m_cnt[0]);
    check("tick4", int'(if4.counter_tick),   m_tick[0]);
    check("fin4",  int'(if4.counter_finish), (m_cnt[0] == (int'(tv) & 15)) ? 1 : 0);
    check("cnt3",  int'(if3.count),          m_cnt[1]);
    check("tick3", int'(if3.counter_tick),   m_tick[1]);
    check("fin3",  int'(if3.counter_finish), (m_cnt[1] == (int'(tv) & 7)) ? 1 : 0);
  endfunction

  // Single compare process. It advances the model on every edge, including
  // the asynchronous reset edge, and checks the outputs 1 ns later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_edge();
    #1;
    compare_all();
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic async_pulse();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int first, second, ticks;
    int seq5[5];
    seq5 = '{6, 7, 0, 1, 2};

    rst_n = 1'b1; rst_syn = 1'b1; en = 1'b1; load = 1'b0;
    dir = 1'b1; wrap = 1'b0; lv = 4'd0; tv = 4'd7; ps = 8'd0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_cnt3",  int'(if3.count), 0);
    check("rst_tick3", int'(if3.counter_tick), 0);
    check("rst_fin3",  int'(if3.counter_finish), 0);
    cycle();
    rst_n = 1'b1;

    // The 3-bit counter runs up to 7 and saturates, with a single tick.
    for (int i = 1; i <= 7; i++) begin
      cycle();
      check("t1_cnt",  int'(if3.count), i);
      check("t1_tick", int'(if3.counter_tick), (i == 7) ? 1 : 0);
    end
    check("t1_fin", int'(if3.counter_finish), 1);
    cycle();
    check("t1_hold", int'(if3.count), 7);
    check("t1_tick_once", int'(if3.counter_tick), 0);

    // Prescale 3, wrap 2..5: the count steps every 4 cycles and the period is 16 cycles.
    load = 1'b1; lv = 4'd2; tv = 4'd5; ps = 8'd3; wrap = 1'b1; dir = 1'b1;
    cycle();
    check("t2_load", int'(if4.count), 2);
    load = 1'b0;
    first = -1; second = -1;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      if (i == 4) check("t2_step", int'(if4.count), 3);
      if (if4.counter_tick) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    check("t2_first_tick", first, 12);
    check("t2_period", second - first, 16);

    // Count down from 9 and saturate at 4, then disable the counter.
    load = 1'b1; lv = 4'd9; dir = 1'b0; wrap = 1'b0; tv = 4'd4; ps = 8'd0;
    cycle();
    check("t3_load", int'(if4.count), 9);
    load = 1'b0;
    ticks = 0;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      if (i == 5) check("t3_reach", int'(if4.count), 4);
      ticks += int'(if4.counter_tick);
    end
    check("t3_one_tick", ticks, 1);
    check("t3_hold", int'(if4.count), 4);
    en = 1'b0;
    cycle();
    check("t3_en_low", int'(if4.count), 0);
    en = 1'b1;

    // Synchronous clear beats Load and also clears the reload value.
    rst_syn = 1'b0; load = 1'b1; lv = 4'd6;
    cycle();
    check("t4_clr", int'(if4.count), 0);
    rst_syn = 1'b1; load = 1'b0; tv = 4'd3; dir = 1'b1; wrap = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cycle();
      if (i == 3) check("t4_term", int'(if4.count), 3);
      if (i == 4) check("t4_reload0", int'(if4.count), 0);
    end
    en = 1'b0; load = 1'b1; lv = 4'd5;
    cycle();
    check("t4_load_en0", int'(if4.count), 5);
    load = 1'b0; en = 1'b1;

    // The 3-bit counter wraps up through 0 to reach terminal 2.
    load = 1'b1; lv = 4'd5; tv = 4'd2; dir = 1'b1; wrap = 1'b0; ps = 8'd0;
    cycle();
    check("t5_load", int'(if3.count), 5);
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t5_cnt", int'(if3.count), seq5[i]);
    end
    check("t5_tick", int'(if3.counter_tick), 1);

    // An asynchronous reset while the tick is high clears everything at once.
    load = 1'b1; lv = 4'd2; tv = 4'd3; wrap = 1'b0;
    cycle();
    load = 1'b0;
    cycle();
    check("t6_tick_pending", int'(if4.counter_tick), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_cnt",  int'(if4.count), 0);
    check("t6_async_tick", int'(if4.counter_tick), 0);
    #1 rst_n = 1'b1;
    cycle();
    check("t6_restart", int'(if4.count), 1);
    cycle();
    cycle();
    check("t6_cnt3",  int'(if4.count), 3);
    check("t6_tick3", int'(if4.counter_tick), 1);

    // Randomised run, checked against the model on every edge.
    for (int n = 0; n < 3000; n++) begin
      cycle();
      rst_syn = ($urandom_range(99) >= 2);
      load    = ($urandom_range(99) < 4);
      en      = ($urandom_range(99) >= 4);
      lv      = 4'($urandom_range(15));
      if ($urandom_range(9) == 0)  dir  = 1'($urandom_range(1));
      if ($urandom_range(9) == 0)  wrap = 1'($urandom_range(1));
      if ($urandom_range(19) == 0) tv   = 4'($urandom_range(15));
      if ($urandom_range(19) == 0) ps   = 8'($urandom_range(3));
      if ($urandom_range(199) == 0) async_pulse();
    end

    cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
